// File: rtl/add_32_pkg.sv
// Shared types and constants for the pipelined 32-bit KGP adder.
package add_32_pkg;

  localparam int unsigned ADD_WIDTH = 32;
  localparam int unsigned ADD_LAT   = 4;
  localparam int unsigned ADD_TAG_W = 4;

  // Carry-state encoding of one KGP pair; resolved pairs are KILL or GEN only.
  localparam logic [1:0] KGP_KILL = 2'b00;
  localparam logic [1:0] KGP_PROP = 2'b10;
  localparam logic [1:0] KGP_GEN  = 2'b11;

  // One completed addition as it sits in the write-back FIFO.
  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 cout;
    logic [ADD_TAG_W-1:0] tag;
  } add_result_t;

endpackage

// File: rtl/add_32_result_fifo.sv
// Circular result FIFO with occupancy count, shared by the write-back paths.
module add_32_result_fifo
  import add_32_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         rec_t = add_result_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  rec_t                       push_data,
  input  logic                       pop,
  output rec_t                       head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // Pop needs a valid head; a push at full is legal only into the slot a pop frees.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop && (count != '0);
    do_push = push && (!full || do_pop);
  end

  // Storage; cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks push/pop balance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head comes straight from storage, so it holds while the consumer stalls.
  always_comb begin
    head  = mem[rd_ptr];
    valid = (count != '0);
  end

`ifndef SYNTHESIS
  // The credit scheme upstream must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(push && full && !pop))
        else $error("result fifo overflow: push while full");
    end
  end
`endif

endmodule

// File: rtl/add_32_sum_stage.sv
// Final adder stage: aligns propagate bits with resolved carries, forms sum/cout, buffers results.
module add_32_sum_stage
  import add_32_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned LAT   = ADD_LAT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ADD_TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [WIDTH-1:0]   issue_p,
  input  logic [TAG_W-1:0]   issue_tag,
  input  logic [2*WIDTH-1:0] kgp_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int unsigned INF_W = $clog2(LAT + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = $clog2(DEPTH + LAT + 1);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] p;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t             line_q [LAT];
  logic [INF_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               accepted;
  logic [WIDTH-1:0]   carry;
  logic [WIDTH-1:0]   kgp_bad;
  add_result_t        arrive_rec;
  add_result_t        head_rec;

  // Credit: everything already buffered or still in the prefix pipeline must fit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LAT); i++) inflight = inflight + INF_W'(line_q[i].valid);
    issue_ready = (CRD_W'(fifo_count) + CRD_W'(inflight)) < CRD_W'(DEPTH);
    accepted    = issue_valid && issue_ready;
  end

  // Delay line shifts unconditionally, matching the non-stallable prefix pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LAT); i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= {accepted, issue_p, issue_tag};
      for (int i = 1; i < int'(LAT); i++) line_q[i] <= line_q[i-1];
    end
  end

  // Resolved carry out of bit i is the high bit of pair i; flag any unresolved pair.
  always_comb begin
    carry   = '0;
    kgp_bad = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry[i]   = kgp_res[2*i+1];
      kgp_bad[i] = !((kgp_res[2*i +: 2] == KGP_KILL) || (kgp_res[2*i +: 2] == KGP_GEN));
    end
  end

  // Sum for the arriving entry; carry-in to bit 0 is already folded into pair 0.
  always_comb begin
    arrive_rec      = '0;
    arrive_rec.sum  = line_q[LAT-1].p ^ {carry[WIDTH-2:0], 1'b0};
    arrive_rec.cout = carry[WIDTH-1];
    arrive_rec.tag  = line_q[LAT-1].tag;
  end

  add_32_result_fifo #(
    .DEPTH (DEPTH),
    .rec_t (add_result_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (line_q[LAT-1].valid),
    .push_data (arrive_rec),
    .pop       (out_ready),
    .head      (head_rec),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  // Head record fields onto the output ports.
  always_comb begin
    out_sum  = head_rec.sum;
    out_cout = head_rec.cout;
    out_tag  = head_rec.tag;
  end

`ifndef SYNTHESIS
  // Carries reaching this stage must be fully resolved (KILL or GEN).
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (kgp_bad == '0)
        else $error("unresolved KGP pair on kgp_res: %h", kgp_res);
    end
  end
`endif

endmodule
